cpack_dict_match: RTL
=====================

Name: cpack_dict_match

Overview:
- Compressor-side reader of the 16-entry pair-write dictionary: per accepted pair, compares two 32-bit input words against all dictionary entries and classifies each word (zero, partial or full match, miss).
- Emits pattern code and match index per word to the code packer, and drives the dictionary's two write lanes (wr, wr2) to push new words.
- Stalls upstream so each new pair always sees all pushes from the previous pair.

Parameters:
- DATA_WIDTH, 32, word width; byte-based match classes require 32.
- TOTAL_WORDS, 16, number of dictionary entries on i_dict.
- IDX_W, $clog2(TOTAL_WORDS), match index width.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  asynchronous active-low reset.
- i_dict  input  TOTAL_WORDS*DATA_WIDTH  flattened dictionary; entry k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  input  1  upstream pair valid.
- o_ready  output  1  upstream ready.
- i_word1  input  DATA_WIDTH  first word of pair.
- i_word2  input  DATA_WIDTH  second word of pair.
- i_word2_vld  input  1  word2 present (0 = odd tail).
- o_valid  output  1  result valid.
- i_ready  input  1  downstream ready.
- o_code1, o_code2  output  3  pattern codes.
- o_idx1, o_idx2  output  IDX_W  matched entry index (0 if no match used).
- o_vld2  output  1  word2 result meaningful.
- o_push1  output  1  drives dictionary wr (lane 1).
- o_push2  output  1  drives dictionary wr2 (lane 2).
- o_push_data1, o_push_data2  output  DATA_WIDTH  drive w_data / w_data2.

Behaviour:
- Reset: o_valid=0, all codes, indices and vld2 = 0, push outputs = 0, stats counters = 0.
- Reset mid-operation discards any held result; no push is issued.
- Codes: 0 ZZZZ (word==0), 1 XXXX (miss), 2 MMMM (full match), 3 MMXX (upper 16 bits match), 4 ZZZX (upper 24 bits zero, low byte nonzero), 5 MMMX (upper 24 bits match); 6 and 7 are unused.
- Classification priority: ZZZZ > MMMM > ZZZX > MMMX > MMXX > XXXX.
- Within a match class the lowest entry index wins. ZZZZ, ZZZX and XXXX report idx=0.
- Both words compare against i_dict as sampled in the accept cycle only. Word2 is never compared against word1.
- Accept when i_valid & o_ready. Classification is combinational in the accept cycle and registered at the clock edge. o_valid rises the next cycle, so latency is 1.
- Output is held stable while o_valid & !i_ready. It is cleared or replaced on transfer (o_valid & i_ready).
- Push rule: push when code is XXXX, MMXX or MMMX. ZZZZ, ZZZX and MMMM never push. Word2 pushes only if o_vld2.
- o_push1 = push1_q & o_valid & i_ready (same for push2), so each push fires exactly once, in the transfer cycle. o_push_data = registered word.
- Both pushes may fire in one cycle (maps to the writer's wr & wr2 case).
- o_ready = !o_valid | (i_ready & !push1_q & !push2_q).
  - A transfer with pushes therefore inserts one bubble; the next pair is accepted no earlier than the cycle after the dictionary write edge.
  - A transfer without pushes allows back-to-back acceptance (full throughput).
- i_word2_vld=0: o_vld2=0, o_code2=0, o_idx2=0, no lane-2 push.

Optional Feature:
- Macro DICT_MATCH_STATS_EN.
- Defined: extra outputs o_cnt_words (16-bit) and o_cnt_full (16-bit), saturating at 16'hFFFF.
  - o_cnt_words increments by 1 or 2 per transfer (by valid words).
  - o_cnt_full increments by the number of MMMM codes per transfer.
  - Both reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Dict all 0; pair (0x00000000, 0x000000AB), vld2=1 -> o_valid next cycle: code1=0, code2=4, idx 0/0, no push, o_ready stays 1.
- Dict all 0; pair (0x12345678, 0x0000ABCD) -> code1=1, code2=3 idx2=0; on transfer o_push1=1 data 0x12345678, o_push2=1 data 0x0000ABCD; o_ready=0 that cycle.
- Entries 3 and 9 = 0xDEADBEEF; word1=0xDEADBEEF, word2=0xDEADBE00 -> code1=2 idx1=3; code2=5 idx2=3; only lane 2 pushes.
- Hold i_ready=0 for 4 cycles with pending push -> outputs stable, o_push1/2=0 and o_ready=0 throughout; single push pulse when i_ready=1.
- Back-to-back full-match pairs with i_ready=1 -> one result per cycle, o_ready never drops. Pair with i_word2_vld=0 and word1 miss -> only o_push1, o_vld2=0.
- Assert i_reset low while o_valid=1 with push pending -> o_valid=0 immediately, no push; after release the first pair sees unmodified dict.

Source files
------------

// File: rtl/cpack_dict_match.sv
// Pair-wise dictionary matcher for the compressor: classifies two words against
// the 16-entry dictionary and drives its pair write lanes. Stats: DICT_MATCH_STATS_EN.
module cpack_dict_match #(
    parameter int DATA_WIDTH  = 32,
    parameter int TOTAL_WORDS = 16,
    parameter int IDX_W       = $clog2(TOTAL_WORDS)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [TOTAL_WORDS*DATA_WIDTH-1:0] i_dict,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_WIDTH-1:0]             i_word1,
    input  logic [DATA_WIDTH-1:0]             i_word2,
    input  logic                              i_word2_vld,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [2:0]                        o_code1,
    output logic [2:0]                        o_code2,
    output logic [IDX_W-1:0]                  o_idx1,
    output logic [IDX_W-1:0]                  o_idx2,
    output logic                              o_vld2,
    output logic                              o_push1,
    output logic                              o_push2,
    output logic [DATA_WIDTH-1:0]             o_push_data1,
    output logic [DATA_WIDTH-1:0]             o_push_data2
`ifdef DICT_MATCH_STATS_EN
    ,
    output logic [15:0]                       o_cnt_words,
    output logic [15:0]                       o_cnt_full
`endif
);

    localparam logic [2:0] CODE_ZZZZ = 3'd0;
    localparam logic [2:0] CODE_XXXX = 3'd1;
    localparam logic [2:0] CODE_MMMM = 3'd2;
    localparam logic [2:0] CODE_MMXX = 3'd3;
    localparam logic [2:0] CODE_ZZZX = 3'd4;
    localparam logic [2:0] CODE_MMMX = 3'd5;

    typedef struct packed {
        logic [2:0]       code;
        logic [IDX_W-1:0] idx;
        logic             push;
    } cls_t;

    // Scan high to low so the lowest matching entry is the one left standing.
    function automatic cls_t classify(
        input logic [DATA_WIDTH-1:0]             w,
        input logic [TOTAL_WORDS*DATA_WIDTH-1:0] dict
    );
        cls_t                  r;
        logic [DATA_WIDTH-1:0] e;
        logic                  hit_f;
        logic                  hit_3;
        logic                  hit_2;
        logic [IDX_W-1:0]      idx_f;
        logic [IDX_W-1:0]      idx_3;
        logic [IDX_W-1:0]      idx_2;
        r     = '0;
        hit_f = 1'b0;
        hit_3 = 1'b0;
        hit_2 = 1'b0;
        idx_f = '0;
        idx_3 = '0;
        idx_2 = '0;
        for (int k = TOTAL_WORDS - 1; k >= 0; k--) begin
            e = dict[k*DATA_WIDTH +: DATA_WIDTH];
            if (e == w) begin
                hit_f = 1'b1;
                idx_f = IDX_W'(k);
            end
            if (e[DATA_WIDTH-1:8] == w[DATA_WIDTH-1:8]) begin
                hit_3 = 1'b1;
                idx_3 = IDX_W'(k);
            end
            if (e[DATA_WIDTH-1:16] == w[DATA_WIDTH-1:16]) begin
                hit_2 = 1'b1;
                idx_2 = IDX_W'(k);
            end
        end
        if (w == '0) begin
            r.code = CODE_ZZZZ;
        end else if (hit_f) begin
            r.code = CODE_MMMM;
            r.idx  = idx_f;
        end else if (w[DATA_WIDTH-1:8] == '0) begin
            r.code = CODE_ZZZX;
        end else if (hit_3) begin
            r.code = CODE_MMMX;
            r.idx  = idx_3;
            r.push = 1'b1;
        end else if (hit_2) begin
            r.code = CODE_MMXX;
            r.idx  = idx_2;
            r.push = 1'b1;
        end else begin
            r.code = CODE_XXXX;
            r.push = 1'b1;
        end
        return r;
    endfunction

    cls_t cls1;
    cls_t cls2;

    logic                  valid_q, valid_d;
    logic [2:0]            code1_q, code1_d;
    logic [2:0]            code2_q, code2_d;
    logic [IDX_W-1:0]      idx1_q, idx1_d;
    logic [IDX_W-1:0]      idx2_q, idx2_d;
    logic                  vld2_q, vld2_d;
    logic                  push1_q, push1_d;
    logic                  push2_q, push2_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;

    logic accept;
    logic xfer;

    always_comb begin
        cls1 = classify(i_word1, i_dict);
        cls2 = '0;
        if (i_word2_vld) begin
            cls2 = classify(i_word2, i_dict);
        end
    end

    // A pending push blocks acceptance so the next pair sees the written dict.
    assign o_ready = !valid_q | (i_ready & !push1_q & !push2_q);
    assign accept  = i_valid & o_ready;
    assign xfer    = valid_q & i_ready;

    always_comb begin
        valid_d = valid_q;
        code1_d = code1_q;
        code2_d = code2_q;
        idx1_d  = idx1_q;
        idx2_d  = idx2_q;
        vld2_d  = vld2_q;
        push1_d = push1_q;
        push2_d = push2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        if (accept) begin
            valid_d = 1'b1;
            code1_d = cls1.code;
            code2_d = cls2.code;
            idx1_d  = cls1.idx;
            idx2_d  = cls2.idx;
            vld2_d  = i_word2_vld;
            push1_d = cls1.push;
            push2_d = cls2.push;
            data1_d = i_word1;
            data2_d = i_word2_vld ? i_word2 : '0;
        end else if (xfer) begin
            valid_d = 1'b0;
            code1_d = '0;
            code2_d = '0;
            idx1_d  = '0;
            idx2_d  = '0;
            vld2_d  = 1'b0;
            push1_d = 1'b0;
            push2_d = 1'b0;
            data1_d = '0;
            data2_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            code1_q <= '0;
            code2_q <= '0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            vld2_q  <= 1'b0;
            push1_q <= 1'b0;
            push2_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            valid_q <= valid_d;
            code1_q <= code1_d;
            code2_q <= code2_d;
            idx1_q  <= idx1_d;
            idx2_q  <= idx2_d;
            vld2_q  <= vld2_d;
            push1_q <= push1_d;
            push2_q <= push2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_code1      = code1_q;
    assign o_code2      = code2_q;
    assign o_idx1       = idx1_q;
    assign o_idx2       = idx2_q;
    assign o_vld2       = vld2_q;
    assign o_push1      = push1_q & xfer;
    assign o_push2      = push2_q & xfer;
    assign o_push_data1 = data1_q;
    assign o_push_data2 = data2_q;

`ifdef DICT_MATCH_STATS_EN
    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [1:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] cnt_words_q, cnt_words_d;
    logic [15:0] cnt_full_q, cnt_full_d;
    logic [1:0]  words_inc;
    logic [1:0]  full_inc;

    always_comb begin
        words_inc   = {1'b0, 1'b1} + {1'b0, vld2_q};
        full_inc    = {1'b0, code1_q == CODE_MMMM}
                    + {1'b0, vld2_q && (code2_q == CODE_MMMM)};
        cnt_words_d = cnt_words_q;
        cnt_full_d  = cnt_full_q;
        if (xfer) begin
            cnt_words_d = sat_add(cnt_words_q, words_inc);
            cnt_full_d  = sat_add(cnt_full_q, full_inc);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_words_q <= '0;
            cnt_full_q  <= '0;
        end else begin
            cnt_words_q <= cnt_words_d;
            cnt_full_q  <= cnt_full_d;
        end
    end

    assign o_cnt_words = cnt_words_q;
    assign o_cnt_full  = cnt_full_q;
`endif

endmodule
